mpi_host_arb: RTL and testbench

- Host-side sequencer and two-requester arbiter for the MPI register port (6-bit address, 8-bit bidirectional data, Mpi_cs_n, Mpi_rw).
- Accepts register read/write requests from two internal masters and picks one.
- Drives the MPI access waveform: setup, chip-select strobe, hold, then bus turnaround.
- Returns read data and a per-requester completion pulse. Sits between the internal masters and the MPI block instance.

---
 rtl/mpi_pkg.sv | 27 ++
 rtl/mpi_host_arb_if.sv | 28 ++
 rtl/mpi_rr_arb2.sv | 43 ++++
 rtl/mpi_host_arb.sv | 153 +++++++++++++++
 tb/tb_mpi_host_arb.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mpi_pkg.sv
// rtl/mpi_pkg.sv - shared FSM encoding, MPI default widths and idle bus levels for the MPI host arbiter.
package mpi_pkg;

  localparam int MPI_ADDR_W = 6;
  localparam int MPI_DATA_W = 8;

  localparam logic CS_N_IDLE = 1'b1;
  localparam logic RW_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } mpi_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/mpi_host_arb_if.sv
// rtl/mpi_host_arb_if.sv - requester and MPI strobe signals of the host arbiter; slave = arbiter side.
interface mpi_host_arb_if #(
  parameter int ADDR_W = mpi_pkg::MPI_ADDR_W,
  parameter int DATA_W = mpi_pkg::MPI_DATA_W
);

  logic [1:0]          Req;
  logic [1:0]          Rw;
  logic [2*ADDR_W-1:0] Addr;
  logic [2*DATA_W-1:0] Wdata;
  logic [1:0]          Ack;
  logic [DATA_W-1:0]   Rdata;
  logic                Busy;
  logic [ADDR_W-1:0]   Mpi_addr;
  logic                Mpi_cs_n;
  logic                Mpi_rw;

  modport slave (
    input  Req, Rw, Addr, Wdata,
    output Ack, Rdata, Busy, Mpi_addr, Mpi_cs_n, Mpi_rw
  );

  modport master (
    output Req, Rw, Addr, Wdata,
    input  Ack, Rdata, Busy, Mpi_addr, Mpi_cs_n, Mpi_rw
  );

endinterface

// File: rtl/mpi_rr_arb2.sv
// rtl/mpi_rr_arb2.sv - two-way grant; round-robin on a last-grant register, or fixed priority
// to requester 0 when MPI_HOST_ARB_FIXED_PRI_EN is defined.
module mpi_rr_arb2 import mpi_pkg::*; (
`ifndef MPI_HOST_ARB_FIXED_PRI_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       gnt_en,
`endif
  input  logic [1:0] req,
  output logic       gnt_idx
);

`ifdef MPI_HOST_ARB_FIXED_PRI_EN

  assign gnt_idx = req[1] & ~req[0];

`else

  logic last_q;
  logic last_d;

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = last_q;
    endcase
    last_d = gnt_en ? gnt_idx : last_q;
  end

`endif

endmodule

// File: rtl/mpi_host_arb.sv
// rtl/mpi_host_arb.sv - two-requester MPI host sequencer: arbitrate, then setup/strobe/hold/turn.
// MPI_HOST_ARB_FIXED_PRI_EN selects fixed priority instead of round-robin.
module mpi_host_arb import mpi_pkg::*; #(
  parameter int ADDR_W     = MPI_ADDR_W,
  parameter int DATA_W     = MPI_DATA_W,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 5,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 2
) (
  input  logic              Clock,
  input  logic              Rst,
  mpi_host_arb_if.slave     bus,
  inout  wire  [DATA_W-1:0] Mpi_data
);

  // A zero-length turnaround still spends one TURN cycle to issue Ack.
  localparam int TURN_LEN = (TURN_CYC > 0) ? TURN_CYC : 1;
  localparam int CNT_MAX  = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_LEN);
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_LEN - 1);

  mpi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gidx_q, gidx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_idx;
  logic              in_access;
  logic              oe;
  logic [ADDR_W-1:0] mpi_addr;
  logic              mpi_cs_n;
  logic              mpi_rw;
  logic [1:0]        ack;
  logic              busy;

`ifndef MPI_HOST_ARB_FIXED_PRI_EN
  logic gnt_en;
  assign gnt_en = (state_q == ST_IDLE) && (|bus.Req);
`endif

  mpi_rr_arb2 u_arb (
`ifndef MPI_HOST_ARB_FIXED_PRI_EN
    .clk     (Clock),
    .rst     (Rst),
    .gnt_en  (gnt_en),
`endif
    .req     (bus.Req),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gidx_q  <= 1'b0;
      addr_q  <= '0;
      rw_q    <= RW_IDLE;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gidx_q  <= gidx_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gidx_d  = gidx_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.Req) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          gidx_d  = gnt_idx;
          addr_d  = gnt_idx ? bus.Addr[2*ADDR_W-1:ADDR_W] : bus.Addr[ADDR_W-1:0];
          rw_d    = bus.Rw[gnt_idx];
          wdata_d = gnt_idx ? bus.Wdata[2*DATA_W-1:DATA_W] : bus.Wdata[DATA_W-1:0];
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          if (rw_q) rdata_d = Mpi_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_TURN;
          cnt_d   = TURN_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_access = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    mpi_addr  = in_access ? addr_q : '0;
    mpi_rw    = in_access ? rw_q : RW_IDLE;
    mpi_cs_n  = (state_q == ST_STROBE) ? ~CS_N_IDLE : CS_N_IDLE;
    oe        = in_access & ~rw_q;
    ack       = 2'b00;
    if ((state_q == ST_TURN) && (cnt_q == TURN_LD)) ack[gidx_q] = 1'b1;
    busy      = (state_q != ST_IDLE);
  end

  assign Mpi_data     = oe ? wdata_q : {DATA_W{1'bz}};
  assign bus.Mpi_addr = mpi_addr;
  assign bus.Mpi_cs_n = mpi_cs_n;
  assign bus.Mpi_rw   = mpi_rw;
  assign bus.Ack      = ack;
  assign bus.Rdata    = rdata_q;
  assign bus.Busy     = busy;

endmodule

// File: tb/tb_mpi_host_arb.sv
// tb/tb_mpi_host_arb.sv - self-checking bench for mpi_host_arb (default and short-timing instances).
module tb_mpi_host_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_c;
  logic tb_oe;
  logic [7:0] tb_val;

  wire [7:0] mpi_data;
  wire [7:0] mpi_data_c;
  assign mpi_data = tb_oe ? tb_val : 8'hzz;

  mpi_host_arb_if #(.ADDR_W(6), .DATA_W(8)) bus ();
  mpi_host_arb_if #(.ADDR_W(6), .DATA_W(8)) bus_c ();

  mpi_host_arb #(.ADDR_W(6), .DATA_W(8), .SETUP_CYC(2), .STROBE_CYC(5), .HOLD_CYC(1), .TURN_CYC(2)) dut (
    .Clock    (clk),
    .Rst      (rst),
    .bus      (bus),
    .Mpi_data (mpi_data)
  );

  mpi_host_arb #(.ADDR_W(6), .DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(0)) dut_c (
    .Clock    (clk),
    .Rst      (rst_c),
    .bus      (bus_c),
    .Mpi_data (mpi_data_c)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] ack;
    logic       busy;
    logic       cs_n;
    logic       rw;
    logic [5:0] addr;
    logic       oe;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[24];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any Ack on the default instance; t counts cycles.
  task automatic wait_ack(input string nm, inout int t, output logic [1:0] a);
    while (bus.Ack == 2'b00 && t < 200) begin
      step();
      t++;
    end
    a = bus.Ack;
    if (a == 2'b00) chk({nm, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [1:0] a;
    logic [1:0] exp_g[4];
    int t;
    int ack0_cnt;
    int ack1_cnt;

    // write (rows 0-11) then read-back by requester 1 (rows 12-23)
    vecs[0] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 6'h00, 1'b0, 8'h00};
    vecs[1] = '{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 6'h2F, 1'b1, 8'h00};
    vecs[2] = vecs[1];
    for (int k = 3; k <= 7; k++) vecs[k] = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 6'h2F, 1'b1, 8'h00};
    vecs[8]  = vecs[1];
    vecs[9]  = '{2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 6'h00, 1'b0, 8'h00};
    vecs[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 6'h00, 1'b0, 8'h00};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 6'h00, 1'b0, 8'h00};
    vecs[12] = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 6'h00, 1'b0, 8'h00};
    vecs[13] = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 6'h2F, 1'b0, 8'h00};
    vecs[14] = vecs[13];
    for (int k = 15; k <= 19; k++) vecs[k] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 6'h2F, 1'b0, 8'h00};
    vecs[20] = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 6'h2F, 1'b0, 8'hA5};
    vecs[21] = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 6'h00, 1'b0, 8'hA5};
    vecs[22] = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 6'h00, 1'b0, 8'hA5};
    vecs[23] = '{2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 6'h00, 1'b0, 8'hA5};

`ifdef MPI_HOST_ARB_FIXED_PRI_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    tb_oe = 1'b0;
    tb_val = 8'hA5;
    bus.Req = 2'b00;   bus.Rw = 2'b00;   bus.Addr = '0;   bus.Wdata = '0;
    bus_c.Req = 2'b00; bus_c.Rw = 2'b00; bus_c.Addr = '0; bus_c.Wdata = '0;
    rst = 1'b1;
    rst_c = 1'b1;
    step();
    step();
    rst = 1'b0;
    rst_c = 1'b0;

    chk("reset cs_n", bus.Mpi_cs_n, 1'b1);
    chk("reset rw", bus.Mpi_rw, 1'b1);
    chk("reset addr", bus.Mpi_addr, 6'h00);
    chk("reset oe", dut.oe, 1'b0);
    chk("reset ack", bus.Ack, 2'b00);
    chk("reset rdata", bus.Rdata, 8'h00);
    chk("reset busy", bus.Busy, 1'b0);
    chk("reset corner busy", bus_c.Busy, 1'b0);

    bus.Rw = 2'b10;
    bus.Addr = {6'h2F, 6'h2F};
    bus.Wdata = {8'h00, 8'hA5};
    for (int i = 0; i < 24; i++) begin
      bus.Req = vecs[i].req;
      tb_oe = (i >= 12);
      chk($sformatf("row%0d ack", i), bus.Ack, vecs[i].ack);
      chk($sformatf("row%0d busy", i), bus.Busy, vecs[i].busy);
      chk($sformatf("row%0d cs_n", i), bus.Mpi_cs_n, vecs[i].cs_n);
      chk($sformatf("row%0d rw", i), bus.Mpi_rw, vecs[i].rw);
      chk($sformatf("row%0d addr", i), bus.Mpi_addr, vecs[i].addr);
      chk($sformatf("row%0d oe", i), dut.oe, vecs[i].oe);
      chk($sformatf("row%0d rdata", i), bus.Rdata, vecs[i].rdata);
      if (vecs[i].oe) chk($sformatf("row%0d mpi_data", i), mpi_data, 8'hA5);
      step();
    end
    tb_oe = 1'b0;

    // contention from reset with both requests held
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.Req = 2'b11;
    bus.Rw = 2'b00;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack($sformatf("contend ack%0d", k), t, a);
      chk($sformatf("contend grant%0d", k), a, exp_g[k]);
      chk($sformatf("contend time%0d", k), t, 9 + 11 * k);
      step();
      t++;
    end
    bus.Req = 2'b00;
    step(); step(); step();
    chk("contend idle busy", bus.Busy, 1'b0);

    // requester 1 pulses only while requester 0 is in STROBE
    bus.Wdata = {8'h00, 8'h5A};
    bus.Req = 2'b01;
    ack0_cnt = 0;
    ack1_cnt = 0;
    for (t = 0; t < 30; t++) begin
      if (bus.Ack[0]) begin
        ack0_cnt++;
        chk("withdraw ack0 time", t, 9);
      end
      if (bus.Ack[1]) ack1_cnt++;
      if (t == 4) chk("withdraw in strobe", bus.Mpi_cs_n, 1'b0);
      bus.Req[0] = bus.Req[0] & ~bus.Ack[0];
      bus.Req[1] = (t == 4);
      step();
    end
    chk("withdraw ack0 count", ack0_cnt, 1);
    chk("withdraw ack1 count", ack1_cnt, 0);
    chk("withdraw busy", bus.Busy, 1'b0);

    // reset in the third STROBE cycle of a requester-0 write
    bus.Wdata = {8'h00, 8'h3C};
    bus.Req = 2'b01;
    for (t = 0; t < 5; t++) step();
    chk("midrst cs_n before", bus.Mpi_cs_n, 1'b0);
    chk("midrst oe before", dut.oe, 1'b1);
    chk("midrst data before", mpi_data, 8'h3C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst cs_n", bus.Mpi_cs_n, 1'b1);
    chk("midrst rw", bus.Mpi_rw, 1'b1);
    chk("midrst addr", bus.Mpi_addr, 6'h00);
    chk("midrst oe", dut.oe, 1'b0);
    chk("midrst ack", bus.Ack, 2'b00);
    chk("midrst busy", bus.Busy, 1'b0);
    chk("midrst rdata", bus.Rdata, 8'h00);
    bus.Req = 2'b11;
    t = 0;
    wait_ack("midrst ack", t, a);
    chk("midrst grant", a, 2'b01);
    chk("midrst time", t, 9);
    bus.Req = 2'b00;
    step(); step(); step();

    // short-timing instance with requester 0 held continuously
    bus_c.Req = 2'b01;
    bus_c.Addr = {6'h00, 6'h15};
    bus_c.Wdata = {8'h00, 8'h77};
    for (t = 0; t < 12; t++) begin
      if (t == 1) chk("corner setup cs_n", bus_c.Mpi_cs_n, 1'b1);
      if (t == 2) chk("corner strobe cs_n", bus_c.Mpi_cs_n, 1'b0);
      if (t == 3) chk("corner hold cs_n", bus_c.Mpi_cs_n, 1'b1);
      if (t == 3) chk("corner hold addr", bus_c.Mpi_addr, 6'h15);
      if (t == 5) chk("corner idle busy", bus_c.Busy, 1'b0);
      if (t == 6) chk("corner 2nd setup addr", bus_c.Mpi_addr, 6'h15);
      chk($sformatf("corner ack t%0d", t), bus_c.Ack, (t == 4 || t == 9) ? 2'b01 : 2'b00);
      step();
    end
    bus_c.Req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
